// File: rtl/rx_symbol_pkg.sv
// Shared symbol definitions for the receive symbol demultiplexer.
package rx_symbol_pkg;

  // Control codes (shared with the transmit symbol mux).
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_COM = 8'hBC;

  // Link-level receive states.
  typedef enum logic [2:0] {
    LINK,
    PKT,
    OS1,
    OS2,
    OS3
  } state_t;

  // Ordered-set type encodings reported on os_type.
  localparam logic [1:0] OS_NONE = 2'b00;
  localparam logic [1:0] OS_SKP  = 2'b01;
  localparam logic [1:0] OS_IDL  = 2'b10;
  localparam logic [1:0] OS_FTS  = 2'b11;

  // Map a control code to its ordered-set type; OS_NONE if it is not one.
  function automatic logic [1:0] os_code_type(input logic [7:0] sym);
    logic [1:0] t;
    t = OS_NONE;
    if (sym == K_SKP) t = OS_SKP;
    else if (sym == K_IDL) t = OS_IDL;
    else if (sym == K_FTS) t = OS_FTS;
    return t;
  endfunction

endpackage

// File: rtl/rx_os_detect.sv
// Ordered-set matcher: after COM, expects three identical SKP/IDL/FTS
// control symbols. Latches the type on the first one and reports, for the
// current symbol, whether the set advances, completes or breaks.
module rx_os_detect
  import rx_symbol_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  state_t     state,
  input  logic [7:0] sym,
  input  logic       is_data,
  output logic       os_advance,
  output logic       os_complete,
  output logic       os_mismatch,
  output logic [1:0] os_type
);

  logic [1:0] type_reg;
  logic [1:0] sym_type;

  assign sym_type = is_data ? OS_NONE : os_code_type(sym);
  assign os_type  = type_reg;

  // Classify the current symbol against the ordered-set progress.
  always_comb begin
    os_advance  = 1'b0;
    os_complete = 1'b0;
    os_mismatch = 1'b0;
    case (state)
      OS1: begin
        if (sym_type != OS_NONE) os_advance = 1'b1;
        else os_mismatch = 1'b1;
      end
      OS2: begin
        if (sym_type == type_reg) os_advance = 1'b1;
        else os_mismatch = 1'b1;
      end
      OS3: begin
        if (sym_type == type_reg) os_complete = 1'b1;
        else os_mismatch = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the set type from the first symbol after COM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_reg <= OS_NONE;
    end else if (state == OS1 && sym_type != OS_NONE) begin
      type_reg <= sym_type;
    end
  end

endmodule

// File: rtl/rx_symbol_demux.sv
// Receive symbol demultiplexer: splits the decoded symbol stream into
// framed packet payload, completed ordered sets and protocol-error strobes.
module rx_symbol_demux
  import rx_symbol_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       D_in,
  input  logic             valid,
  output logic [7:0]       D_out,
  output logic             data_valid,
  output logic             pkt_start,
  output logic             pkt_is_dllp,
  output logic             pkt_end,
  output logic             pkt_bad,
  output logic [LEN_W-1:0] pkt_len,
  output logic             os_valid,
  output logic [1:0]       os_type,
  output logic             sym_err
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       d_out_reg, d_out_next;
  logic             data_valid_reg, data_valid_next;
  logic             pkt_start_reg, pkt_start_next;
  logic             dllp_reg, dllp_next;
  logic             pkt_end_reg, pkt_end_next;
  logic             pkt_bad_reg, pkt_bad_next;
  logic [LEN_W-1:0] pkt_len_reg, pkt_len_next;
  logic             os_valid_reg, os_valid_next;
  logic [1:0]       os_type_reg, os_type_next;
  logic             sym_err_reg, sym_err_next;

  logic             os_advance, os_complete, os_mismatch;
  logic [1:0]       det_type;
  logic             link_rules;
  logic             is_ctrl;

  assign is_ctrl = ~valid;

  rx_os_detect u_os_detect (
    .clk         (clk),
    .reset       (reset),
    .state       (state_reg),
    .sym         (D_in),
    .is_data     (valid),
    .os_advance  (os_advance),
    .os_complete (os_complete),
    .os_mismatch (os_mismatch),
    .os_type     (det_type)
  );

  // Next-state and next-output decode for one symbol.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    d_out_next      = d_out_reg;
    data_valid_next = 1'b0;
    pkt_start_next  = 1'b0;
    dllp_next       = dllp_reg;
    pkt_end_next    = 1'b0;
    pkt_bad_next    = pkt_bad_reg;
    pkt_len_next    = pkt_len_reg;
    os_valid_next   = 1'b0;
    os_type_next    = os_type_reg;
    sym_err_next    = 1'b0;
    link_rules      = 1'b0;

    case (state_reg)
      OS1, OS2: begin
        if (os_advance) begin
          state_next = (state_reg == OS1) ? OS2 : OS3;
        end else if (os_mismatch) begin
          sym_err_next = 1'b1;
          link_rules   = 1'b1;
        end
      end
      OS3: begin
        if (os_complete) begin
          os_valid_next = 1'b1;
          os_type_next  = det_type;
          state_next    = LINK;
        end else if (os_mismatch) begin
          sym_err_next = 1'b1;
          link_rules   = 1'b1;
        end
      end
      PKT: begin
        if (valid) begin
          data_valid_next = 1'b1;
          d_out_next      = D_in;
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + LEN_W'(1);
        end else begin
          // Every control symbol closes the current packet one way or another.
          pkt_end_next = 1'b1;
          pkt_len_next = cnt_reg;
          pkt_bad_next = 1'b1;
          state_next   = LINK;
          if (D_in == K_END) begin
            pkt_bad_next = (cnt_reg == '0);
          end else if (D_in == K_EDB) begin
            pkt_bad_next = 1'b1;
          end else if (D_in == K_STP || D_in == K_SDP) begin
            sym_err_next   = 1'b1;
            pkt_start_next = 1'b1;
            dllp_next      = (D_in == K_SDP);
            cnt_next       = '0;
            state_next     = PKT;
          end else if (D_in == K_COM) begin
            sym_err_next = 1'b1;
            state_next   = OS1;
          end else begin
            sym_err_next = 1'b1;
          end
        end
      end
      default: link_rules = 1'b1;
    endcase

    // Idle-link handling, also used to re-evaluate a symbol that broke an ordered set.
    if (link_rules) begin
      if (is_ctrl && (D_in == K_STP || D_in == K_SDP)) begin
        state_next     = PKT;
        pkt_start_next = 1'b1;
        dllp_next      = (D_in == K_SDP);
        cnt_next       = '0;
      end else if (is_ctrl && D_in == K_COM) begin
        state_next = OS1;
      end else begin
        state_next   = LINK;
        sym_err_next = 1'b1;
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= LINK;
      cnt_reg        <= '0;
      d_out_reg      <= '0;
      data_valid_reg <= 1'b0;
      pkt_start_reg  <= 1'b0;
      dllp_reg       <= 1'b0;
      pkt_end_reg    <= 1'b0;
      pkt_bad_reg    <= 1'b0;
      pkt_len_reg    <= '0;
      os_valid_reg   <= 1'b0;
      os_type_reg    <= OS_NONE;
      sym_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      d_out_reg      <= d_out_next;
      data_valid_reg <= data_valid_next;
      pkt_start_reg  <= pkt_start_next;
      dllp_reg       <= dllp_next;
      pkt_end_reg    <= pkt_end_next;
      pkt_bad_reg    <= pkt_bad_next;
      pkt_len_reg    <= pkt_len_next;
      os_valid_reg   <= os_valid_next;
      os_type_reg    <= os_type_next;
      sym_err_reg    <= sym_err_next;
    end
  end

  assign D_out       = d_out_reg;
  assign data_valid  = data_valid_reg;
  assign pkt_start   = pkt_start_reg;
  assign pkt_is_dllp = dllp_reg;
  assign pkt_end     = pkt_end_reg;
  assign pkt_bad     = pkt_bad_reg;
  assign pkt_len     = pkt_len_reg;
  assign os_valid    = os_valid_reg;
  assign os_type     = os_type_reg;
  assign sym_err     = sym_err_reg;

endmodule

// File: tb/tb_rx_symbol_demux.sv
// Self-checking bench for rx_symbol_demux: directed scenarios plus a random
// symbol stream, each compared cycle by cycle with a behavioural model.
module tb_rx_symbol_demux;

  localparam int LEN_W = 12;
  localparam int MAXLEN = (1 << LEN_W) - 1;

  localparam logic [7:0] STP = 8'hFB, SDP = 8'h5C, ENDK = 8'hFD, EDB = 8'hFE;
  localparam logic [7:0] SKP = 8'h1C, IDL = 8'h7C, FTS = 8'h3C, COM = 8'hBC;
  localparam logic [7:0] UNK = 8'hF7;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       d_in;
  logic             valid;
  logic [7:0]       d_out;
  logic             data_valid, pkt_start, pkt_is_dllp, pkt_end, pkt_bad;
  logic [LEN_W-1:0] pkt_len;
  logic             os_valid;
  logic [1:0]       os_type;
  logic             sym_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: packet open flag, payload count, ordered-set progress.
  bit         m_in_pkt;
  int         m_cnt;
  int         m_os;       // 0 = none, k = k symbols expected after COM so far (1..3)
  logic [7:0] m_os_code;

  // Expected outputs.
  logic [7:0]       e_dout;
  logic             e_dv, e_start, e_dllp, e_end, e_bad, e_osv, e_err;
  logic [LEN_W-1:0] e_len;
  logic [1:0]       e_ostype;

  rx_symbol_demux #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .D_in        (d_in),
    .valid       (valid),
    .D_out       (d_out),
    .data_valid  (data_valid),
    .pkt_start   (pkt_start),
    .pkt_is_dllp (pkt_is_dllp),
    .pkt_end     (pkt_end),
    .pkt_bad     (pkt_bad),
    .pkt_len     (pkt_len),
    .os_valid    (os_valid),
    .os_type     (os_type),
    .sym_err     (sym_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] C(input logic [7:0] b);
    return {1'b0, b};
  endfunction

  function automatic logic [8:0] D(input logic [7:0] b);
    return {1'b1, b};
  endfunction

  function automatic logic [1:0] enc(input logic [7:0] c);
    if (c == SKP) return 2'b01;
    if (c == IDL) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [28:0] obs_vec();
    return {d_out, data_valid, pkt_start, pkt_is_dllp, pkt_end, pkt_bad,
            pkt_len, os_valid, os_type, sym_err};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {e_dout, e_dv, e_start, e_dllp, e_end, e_bad,
            e_len, e_osv, e_ostype, e_err};
  endfunction

  task automatic model_reset();
    m_in_pkt = 0; m_cnt = 0; m_os = 0; m_os_code = 8'h00;
    e_dout = 8'h00; e_dv = 0; e_start = 0; e_dllp = 0; e_end = 0;
    e_bad = 0; e_len = '0; e_osv = 0; e_ostype = 2'b00; e_err = 0;
  endtask

  // Apply the receive rules to one symbol and update the expected outputs.
  task automatic model_step(input logic [7:0] s, input logic v);
    bit relink;
    bit os_sym;
    e_dv = 0; e_start = 0; e_end = 0; e_osv = 0; e_err = 0;
    relink = 0;
    os_sym = !v && (s == SKP || s == IDL || s == FTS);
    if (m_os != 0) begin
      if (os_sym && (m_os == 1 || s == m_os_code)) begin
        if (m_os == 1) m_os_code = s;
        if (m_os == 3) begin
          e_osv = 1; e_ostype = enc(m_os_code); m_os = 0;
        end else begin
          m_os++;
        end
      end else begin
        e_err = 1; m_os = 0; relink = 1;
      end
    end else if (m_in_pkt) begin
      if (v) begin
        e_dv = 1; e_dout = s;
        if (m_cnt < MAXLEN) m_cnt++;
      end else begin
        e_end = 1; e_len = LEN_W'(m_cnt); m_in_pkt = 0;
        e_bad = (s == ENDK) ? (m_cnt == 0) : 1'b1;
        if (s != ENDK && s != EDB) e_err = 1;
        if (s == STP || s == SDP) begin
          e_start = 1; e_dllp = (s == SDP); m_in_pkt = 1; m_cnt = 0;
        end else if (s == COM) begin
          m_os = 1;
        end
      end
    end else begin
      relink = 1;
    end
    if (relink) begin
      if (!v && (s == STP || s == SDP)) begin
        e_start = 1; e_dllp = (s == SDP); m_in_pkt = 1; m_cnt = 0;
      end else if (!v && s == COM) begin
        m_os = 1;
      end else begin
        e_err = 1;
      end
    end
  endtask

  // Drive one symbol, advance the model, and settle just after the edge.
  task automatic step(input logic [8:0] sym);
    d_in = sym[7:0];
    valid = sym[8];
    model_step(sym[7:0], sym[8]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; d_in = 8'h00; valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 29'd0);
    end
    reset = 0;
    $display("reset: outputs=%h", obs_vec());
  endtask

  task automatic test_good_tlp();
    logic [8:0] q[$];
    q = '{C(STP), D(8'h11), D(8'h22), D(8'h33), C(ENDK)};
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL good_tlp[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pkt_len !== 12'd3 || pkt_bad !== 1'b0 || pkt_end !== 1'b1) begin
      n_errors++;
      $display("FAIL good_tlp_len got len=%0d bad=%b end=%b exp len=3 bad=0 end=1",
               pkt_len, pkt_bad, pkt_end);
    end
    $display("good_tlp: pkt_len=%0d pkt_bad=%b", pkt_len, pkt_bad);
  endtask

  task automatic test_null_empty();
    logic [8:0] q[$];
    q = '{C(SDP), D(8'hAA), C(EDB), C(STP), C(ENDK)};
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL null_empty[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pkt_len !== 12'd0 || pkt_bad !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_pkt got len=%0d bad=%b exp len=0 bad=1", pkt_len, pkt_bad);
    end
    $display("null_empty: pkt_len=%0d pkt_bad=%b", pkt_len, pkt_bad);
  endtask

  task automatic test_ordered_sets();
    logic [8:0] q[$];
    q = '{C(COM), C(SKP), C(SKP), C(SKP), C(COM), C(FTS), C(FTS), C(FTS),
          C(COM), C(IDL), C(IDL), C(SKP)};
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL ordered_sets[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (os_valid !== 1'b1 || os_type !== ((i == 3) ? 2'b01 : 2'b11)) begin
          n_errors++;
          $display("FAIL os_done[%0d] got valid=%b type=%b", i, os_valid, os_type);
        end
      end
    end
    n_checks++;
    if (sym_err !== 1'b1 || os_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL os_mismatch got err=%b osv=%b exp err=1 osv=0", sym_err, os_valid);
    end
    $display("ordered_sets: last os_type=%b sym_err=%b", os_type, sym_err);
  endtask

  task automatic test_aborts();
    logic [8:0] q[$];
    q = '{C(STP), D(8'h01), C(STP), D(8'h02), C(ENDK),
          C(STP), D(8'h05), C(COM), C(SKP), C(SKP), C(SKP)};
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL aborts[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if ({sym_err, pkt_end, pkt_bad, pkt_start} !== 4'b1111 || pkt_len !== 12'd1) begin
          n_errors++;
          $display("FAIL abort_stp got err/end/bad/start=%b len=%0d exp 1111 len=1",
                   {sym_err, pkt_end, pkt_bad, pkt_start}, pkt_len);
        end
      end
    end
    $display("aborts: os_valid=%b os_type=%b", os_valid, os_type);
  endtask

  task automatic test_saturation();
    step(C(STP));
    for (int i = 0; i < 4100; i++) begin
      step(D(8'(i)));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL sat_data[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    step(C(ENDK));
    n_checks++;
    if (pkt_len !== 12'd4095 || pkt_end !== 1'b1) begin
      n_errors++;
      $display("FAIL saturation got len=%0d end=%b exp len=4095 end=1", pkt_len, pkt_end);
    end
    step(D(8'h55));
    n_checks++;
    if (sym_err !== 1'b1 || data_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL stray_data got err=%b dv=%b exp err=1 dv=0", sym_err, data_valid);
    end
    $display("saturation: pkt_len=%0d", pkt_len);
  endtask

  task automatic test_reset_mid();
    step(C(STP));
    step(D(8'h10));
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL pre_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
    #2 reset = 1;
    #1;
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), 29'd0);
    end
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    step(C(ENDK));
    n_checks++;
    if (sym_err !== 1'b1 || pkt_end !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL post_reset_end got err=%b end=%b exp err=1 end=0", sym_err, pkt_end);
    end
    $display("reset_mid: sym_err=%b pkt_end=%b", sym_err, pkt_end);
  endtask

  task automatic test_random();
    logic [7:0] ctl [9];
    logic [7:0] t;
    int r;
    ctl = '{STP, SDP, ENDK, EDB, SKP, IDL, FTS, COM, UNK};
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9) begin
        step(D(8'($urandom)));
      end else if (r == 19) begin
        t = ctl[$urandom_range(4, 6)];
        step(C(COM));
        step(C(t));
        step(C(t));
        step(C(t));
      end else begin
        step(C(ctl[$urandom_range(0, 8)]));
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    $display("random: done 600 iterations");
  endtask

  initial begin
    test_reset();
    test_good_tlp();
    test_null_empty();
    test_ordered_sets();
    test_aborts();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
